multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multicycle successor to the single-cycle control unit. Sequences each MIPS instruction through fetch, decode, execute, memory and write-back states, and drives a shared-memory multicycle datapath with a req/ready memory handshake. Adds configurable memory timeout and trap handling for illegal opcodes and stalled memory, steering the PC to a trap vector.

## Interface
Parameters:
- MEM_TIMEOUT, 16: max wait cycles per memory access before trap; 0 disables the timeout.
- TRAP_EN, 1: 1 = illegal op/timeout traps; 0 = illegal op executes as no-op, timeout disabled.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  6  IR opcode field (valid from DECODE onward)
- funct  in  6  IR funct field
- alu_zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes access this cycle
- mem_req  out  1  memory access request
- iord  out  1  address select: 0 = PC, 1 = ALU-out register
- mem_write  out  1  write strobe (qualifies mem_req)
- mem_rw_size  out  2  2^n bytes
- mem_read_signed  out  1  sign-extend load data
- ir_write  out  1  latch instruction register
- pc_write  out  1  update PC
- pc_src  out  3  0 = ALU result, 1 = ALU-out reg, 2 = jump target, 3 = rs, 4 = trap vector
- reg_write, reg_dst, mem_to_reg, pc_to_reg, write_to_ra  out  1 each  same meanings as single-cycle unit
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  0 = rt, 1 = constant 4, 2 = extended imm, 3 = extended imm << 2
- alu_control  out  4  ALU op from shared package
- use_shamt, imm_extend_mode  out  1 each  as single-cycle unit
- trap  out  1  one-cycle pulse on trap entry
- trap_cause  out  2  0 = illegal op, 1 = memory timeout; holds until next trap
- epc_write  out  1  latch faulting PC (with trap)

## Operation
- States: RESET, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP, JUMP_REG, TRAP.
- RESET: entered while rst_n low. All outputs 0. Goes to FETCH on the first clk after release.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_control=ADDU, pc_src=0. On mem_ready: ir_write=1, pc_write=1, then DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, imm_extend_mode=1, ADDU (branch target to ALU-out).
  - Loads/stores -> MEM_ADDR. R arithmetic -> EXEC_R. Immediate ops -> EXEC_I.
  - beq/bne/blez/bgtz -> BRANCH. j/jal -> JUMP. jr/jalr -> JUMP_REG.
  - Anything else -> TRAP (TRAP_EN=1) or FETCH (TRAP_EN=0).
- MEM_ADDR: rs + sign-extended imm, ADDU. -> MEM_READ (load) or MEM_WRITE (store).
- MEM_READ: mem_req=1, iord=1, size/signed from op (lb/lh/lw/lbu/lhu). On mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, with size/signed held.
- MEM_WRITE: mem_req=1, mem_write=1, iord=1, size from op (sb/sh/sw). On mem_ready -> FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0. alu_control/use_shamt decoded from funct (sllv/srlv/srav use shamt=0).
- EXEC_I: alu_src_b=2, op-specific ALU op. imm_extend_mode=1 for ADD/SUB/SLT/SGT, else 0.
- ALU_WB: reg_write=1, mem_to_reg=0, reg_dst = 1 for R-type, 0 for I-type.
- BRANCH: rs vs rt, SUBU for beq/bne; rs vs $0, SGT for blez/bgtz. pc_src=1. pc_write taken when:
  - beq: alu_zero
  - bne: !alu_zero
  - blez: alu_zero
  - bgtz: !alu_zero
- JUMP: pc_src=2, pc_write=1. jal additionally: reg_write, write_to_ra, pc_to_reg.
- JUMP_REG: pc_src=3, pc_write=1. jalr additionally: reg_write, reg_dst=1, pc_to_reg.
- TRAP: trap=1, epc_write=1, pc_src=4, pc_write=1, trap_cause updated. -> FETCH.
- Last state of every instruction returns to FETCH.
- Timeout: counter clears on entry to FETCH, MEM_READ or MEM_WRITE and increments each cycle without mem_ready. If it reaches MEM_TIMEOUT with no ready and TRAP_EN=1 -> TRAP, cause 1.
- A timeout in FETCH leaves ir_write and pc_write deasserted.

## Timing
- Zero-wait latency: R/I-type 4, load 5, store 4, branch 3, j/jr 3, trap 1 extra cycle. Each ready-less wait cycle adds 1.
- Zero-wait access: mem_ready in the same cycle as mem_req completes the access.
- Mealy outputs: ir_write, pc_write (FETCH, BRANCH) and the next-state transitions. All other outputs are Moore, decoded from state.
- Asynchronous reset mid-instruction: outputs drop to 0 immediately. No memory strobe survives. trap_cause resets to 0.
- mem_ready outside a request state is ignored.
- mem_ready on the exact cycle the counter hits MEM_TIMEOUT: the access completes and there is no trap.

## Structure
- Shared package holds: the state enum, pc_src and alu_src_b encodings, trap cause codes, the existing ALU op codes and op/funct constants.
- Sub-module instr_classifier (combinational): maps op/funct to instruction class, ALU op, mem size/signed and illegal flag. The FSM contains only sequencing logic.

## Test plan
- add $3,$1,$2, mem_ready tied 1 -> FETCH, DECODE, EXEC_R, ALU_WB. Cycle 4: reg_write=1, reg_dst=1, alu_control=ALU_ADD.
- lh with mem_ready delayed 3 cycles in MEM_READ -> 8 cycles total. mem_rw_size=01 and mem_read_signed=1 through MEM_WB.
- bgtz with alu_zero=0 -> pc_write=1, pc_src=1. With alu_zero=1 -> pc_write=0. Both return to FETCH after 3 cycles.
- op=6'h3F with TRAP_EN=1 -> DECODE then TRAP: trap=1, epc_write=1, pc_src=4, trap_cause=0.
- MEM_TIMEOUT=4, sw with mem_ready never asserted -> TRAP on the 4th wait cycle, trap_cause=1, mem_write low afterward.
- rst_n pulsed low during MEM_WRITE -> mem_req/mem_write 0 immediately. After release: RESET, then FETCH.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle MIPS control unit: FSM states,
// datapath mux encodings, trap causes, ALU op codes and op/funct constants.
package multicycle_control_unit_pkg;

   typedef enum logic [3:0] {
      S_RESET,
      S_FETCH,
      S_DECODE,
      S_MEM_ADDR,
      S_MEM_READ,
      S_MEM_WB,
      S_MEM_WRITE,
      S_EXEC_R,
      S_EXEC_I,
      S_ALU_WB,
      S_BRANCH,
      S_JUMP,
      S_JUMP_REG,
      S_TRAP
   } state_t;

   typedef enum logic [2:0] {
      PC_SRC_ALU     = 3'd0,
      PC_SRC_ALU_OUT = 3'd1,
      PC_SRC_JUMP    = 3'd2,
      PC_SRC_RS      = 3'd3,
      PC_SRC_TRAP    = 3'd4
   } pc_src_t;

   typedef enum logic [1:0] {
      ALU_B_RT      = 2'd0,
      ALU_B_FOUR    = 2'd1,
      ALU_B_IMM     = 2'd2,
      ALU_B_IMM_SH2 = 2'd3
   } alu_src_b_t;

   typedef enum logic [1:0] {
      CAUSE_ILLEGAL = 2'd0,
      CAUSE_TIMEOUT = 2'd1
   } trap_cause_t;

   // Access size as log2 of the byte count.
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } mem_size_t;

   // ALU op codes shared with the datapath ALU.
   localparam logic [3:0] ALU_AND  = 4'd0;
   localparam logic [3:0] ALU_OR   = 4'd1;
   localparam logic [3:0] ALU_ADD  = 4'd2;
   localparam logic [3:0] ALU_ADDU = 4'd3;
   localparam logic [3:0] ALU_SUB  = 4'd4;
   localparam logic [3:0] ALU_SUBU = 4'd5;
   localparam logic [3:0] ALU_XOR  = 4'd6;
   localparam logic [3:0] ALU_NOR  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;
   localparam logic [3:0] ALU_SLL  = 4'd10;
   localparam logic [3:0] ALU_SRL  = 4'd11;
   localparam logic [3:0] ALU_SRA  = 4'd12;
   localparam logic [3:0] ALU_LUI  = 4'd13;
   localparam logic [3:0] ALU_SGT  = 4'd14;

   // Opcodes.
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BLEZ  = 6'h06;
   localparam logic [5:0] OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes.
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef enum logic [2:0] {
      CLS_ILLEGAL,
      CLS_LOAD,
      CLS_STORE,
      CLS_R_ALU,
      CLS_I_ALU,
      CLS_BRANCH,
      CLS_JUMP,
      CLS_JUMP_REG
   } instr_class_t;

   // Everything the sequencer needs to know about the current instruction.
   typedef struct packed {
      instr_class_t cls;
      logic [3:0]   alu_op;
      logic         use_shamt;
      logic         imm_signed;
      mem_size_t    mem_size;
      logic         mem_signed;
      logic         link;            // jal / jalr write the return address
      logic         branch_on_zero;  // beq / blez take the branch when alu_zero
      logic         illegal;
   } decode_t;

   // Moore outputs, registered alongside the state.
   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       mem_write;
      mem_size_t  mem_rw_size;
      logic       mem_read_signed;
      pc_src_t    pc_src;
      logic       pc_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       pc_to_reg;
      logic       write_to_ra;
      logic       alu_src_a;
      alu_src_b_t alu_src_b;
      logic [3:0] alu_control;
      logic       use_shamt;
      logic       imm_extend_mode;
      logic       trap;
      logic       epc_write;
   } ctrl_t;

   // Only the signed arithmetic/compare immediates sign-extend.
   function automatic logic imm_sign_extends(input logic [3:0] alu_op);
      return (alu_op == ALU_ADD) || (alu_op == ALU_SUB) ||
             (alu_op == ALU_SLT) || (alu_op == ALU_SGT);
   endfunction

   // States that hold a memory request open and are subject to the timeout.
   function automatic logic is_req_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Memory request/ready handshake between the control unit (master) and the
// shared instruction/data memory (slave).
interface multicycle_control_unit_if;
   import multicycle_control_unit_pkg::*;

   logic      mem_req;
   logic      iord;
   logic      mem_write;
   mem_size_t mem_rw_size;
   logic      mem_read_signed;
   logic      mem_ready;

   modport master (
      output mem_req,
      output iord,
      output mem_write,
      output mem_rw_size,
      output mem_read_signed,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  iord,
      input  mem_write,
      input  mem_rw_size,
      input  mem_read_signed,
      output mem_ready
   );

endinterface

// File: rtl/multicycle_control_unit_instr_classifier.sv
// Combinational instruction classifier: maps op/funct to instruction class,
// ALU op, memory access size/sign and the illegal-instruction flag.
module multicycle_control_unit_instr_classifier
   import multicycle_control_unit_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output decode_t    dec
);

   // Decode op/funct into the instruction descriptor.
   always_comb begin
      // NOTE: every field gets a default before the case so no path can infer a latch.
      dec          = '0;
      dec.cls      = CLS_ILLEGAL;
      dec.mem_size = SIZE_WORD;
      case (op)
         OP_RTYPE: begin
            dec.cls = CLS_R_ALU;
            case (funct)
               FN_SLL:  begin dec.alu_op = ALU_SLL; dec.use_shamt = 1'b1; end
               FN_SRL:  begin dec.alu_op = ALU_SRL; dec.use_shamt = 1'b1; end
               FN_SRA:  begin dec.alu_op = ALU_SRA; dec.use_shamt = 1'b1; end
               FN_SLLV: dec.alu_op = ALU_SLL;
               FN_SRLV: dec.alu_op = ALU_SRL;
               FN_SRAV: dec.alu_op = ALU_SRA;
               FN_JR:   dec.cls    = CLS_JUMP_REG;
               FN_JALR: begin dec.cls = CLS_JUMP_REG; dec.link = 1'b1; end
               FN_ADD:  dec.alu_op = ALU_ADD;
               FN_ADDU: dec.alu_op = ALU_ADDU;
               FN_SUB:  dec.alu_op = ALU_SUB;
               FN_SUBU: dec.alu_op = ALU_SUBU;
               FN_AND:  dec.alu_op = ALU_AND;
               FN_OR:   dec.alu_op = ALU_OR;
               FN_XOR:  dec.alu_op = ALU_XOR;
               FN_NOR:  dec.alu_op = ALU_NOR;
               FN_SLT:  dec.alu_op = ALU_SLT;
               FN_SLTU: dec.alu_op = ALU_SLTU;
               default: dec.cls    = CLS_ILLEGAL;
            endcase
         end
         OP_J:     dec.cls = CLS_JUMP;
         OP_JAL:   begin dec.cls = CLS_JUMP; dec.link = 1'b1; end
         // beq/bne compare rs-rt; blez/bgtz compute rs > 0 so alu_zero means rs <= 0.
         OP_BEQ:   begin dec.cls = CLS_BRANCH; dec.alu_op = ALU_SUBU; dec.branch_on_zero = 1'b1; end
         OP_BNE:   begin dec.cls = CLS_BRANCH; dec.alu_op = ALU_SUBU; end
         OP_BLEZ:  begin dec.cls = CLS_BRANCH; dec.alu_op = ALU_SGT;  dec.branch_on_zero = 1'b1; end
         OP_BGTZ:  begin dec.cls = CLS_BRANCH; dec.alu_op = ALU_SGT;  end
         OP_ADDI:  begin dec.cls = CLS_I_ALU; dec.alu_op = ALU_ADD;  end
         OP_ADDIU: begin dec.cls = CLS_I_ALU; dec.alu_op = ALU_ADDU; end
         OP_SLTI:  begin dec.cls = CLS_I_ALU; dec.alu_op = ALU_SLT;  end
         OP_SLTIU: begin dec.cls = CLS_I_ALU; dec.alu_op = ALU_SLTU; end
         OP_ANDI:  begin dec.cls = CLS_I_ALU; dec.alu_op = ALU_AND;  end
         OP_ORI:   begin dec.cls = CLS_I_ALU; dec.alu_op = ALU_OR;   end
         OP_XORI:  begin dec.cls = CLS_I_ALU; dec.alu_op = ALU_XOR;  end
         OP_LUI:   begin dec.cls = CLS_I_ALU; dec.alu_op = ALU_LUI;  end
         OP_LB:    begin dec.cls = CLS_LOAD; dec.mem_size = SIZE_BYTE; dec.mem_signed = 1'b1; end
         OP_LH:    begin dec.cls = CLS_LOAD; dec.mem_size = SIZE_HALF; dec.mem_signed = 1'b1; end
         OP_LW:    begin dec.cls = CLS_LOAD; dec.mem_size = SIZE_WORD; end
         OP_LBU:   begin dec.cls = CLS_LOAD; dec.mem_size = SIZE_BYTE; end
         OP_LHU:   begin dec.cls = CLS_LOAD; dec.mem_size = SIZE_HALF; end
         OP_SB:    begin dec.cls = CLS_STORE; dec.mem_size = SIZE_BYTE; end
         OP_SH:    begin dec.cls = CLS_STORE; dec.mem_size = SIZE_HALF; end
         OP_SW:    begin dec.cls = CLS_STORE; dec.mem_size = SIZE_WORD; end
         default:  dec.cls = CLS_ILLEGAL;
      endcase
      dec.imm_signed = imm_sign_extends(dec.alu_op);
      dec.illegal    = (dec.cls == CLS_ILLEGAL);
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: sequences each instruction through
// fetch/decode/execute/memory/write-back, runs the memory req/ready handshake
// with a per-access timeout, and steers the PC to the trap vector on illegal
// instructions or stalled memory.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter bit TRAP_EN     = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [5:0]                op,
   input  logic [5:0]                funct,
   input  logic                      alu_zero,
   multicycle_control_unit_if.master mem,
   output logic                      ir_write,
   output logic                      pc_write,
   output logic [2:0]                pc_src,
   output logic                      reg_write,
   output logic                      reg_dst,
   output logic                      mem_to_reg,
   output logic                      pc_to_reg,
   output logic                      write_to_ra,
   output logic                      alu_src_a,
   output logic [1:0]                alu_src_b,
   output logic [3:0]                alu_control,
   output logic                      use_shamt,
   output logic                      imm_extend_mode,
   output logic                      trap,
   output logic [1:0]                trap_cause,
   output logic                      epc_write
);

   localparam bit TIMEOUT_ON = TRAP_EN && (MEM_TIMEOUT > 0);
   localparam int CW         = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   // Wait-counter value during the last ready-less cycle allowed before trapping.
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(MEM_TIMEOUT - 1);

   state_t        state;
   state_t        next_state;
   ctrl_t         ctrl;
   decode_t       dec;
   trap_cause_t   cause_q;
   logic [CW-1:0] wait_cnt;
   logic          timeout_hit;
   logic          branch_taken;

   multicycle_control_unit_instr_classifier u_instr_classifier (
      .op    (op),
      .funct (funct),
      .dec   (dec)
   );

   // Moore output decode for a given state; registered as the state is entered.
   function automatic ctrl_t moore_outputs(input state_t s, input decode_t d);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_req     = 1'b1;
            c.alu_src_b   = ALU_B_FOUR;
            c.alu_control = ALU_ADDU;
         end
         S_DECODE: begin
            c.alu_src_b       = ALU_B_IMM_SH2;
            c.imm_extend_mode = 1'b1;
            c.alu_control     = ALU_ADDU;
         end
         S_MEM_ADDR: begin
            c.alu_src_a       = 1'b1;
            c.alu_src_b       = ALU_B_IMM;
            c.imm_extend_mode = 1'b1;
            c.alu_control     = ALU_ADDU;
         end
         S_MEM_READ: begin
            c.mem_req         = 1'b1;
            c.iord            = 1'b1;
            c.mem_rw_size     = d.mem_size;
            c.mem_read_signed = d.mem_signed;
         end
         S_MEM_WB: begin
            c.reg_write       = 1'b1;
            c.mem_to_reg      = 1'b1;
            c.mem_rw_size     = d.mem_size;
            c.mem_read_signed = d.mem_signed;
         end
         S_MEM_WRITE: begin
            c.mem_req     = 1'b1;
            c.mem_write   = 1'b1;
            c.iord        = 1'b1;
            c.mem_rw_size = d.mem_size;
         end
         S_EXEC_R: begin
            c.alu_src_a   = 1'b1;
            c.alu_src_b   = ALU_B_RT;
            c.alu_control = d.alu_op;
            c.use_shamt   = d.use_shamt;
         end
         S_EXEC_I: begin
            c.alu_src_a       = 1'b1;
            c.alu_src_b       = ALU_B_IMM;
            c.alu_control     = d.alu_op;
            c.imm_extend_mode = d.imm_signed;
         end
         S_ALU_WB: begin
            c.reg_write   = 1'b1;
            c.reg_dst     = (d.cls == CLS_R_ALU);
            c.alu_control = d.alu_op;
            c.use_shamt   = d.use_shamt;
         end
         S_BRANCH: begin
            c.alu_src_a   = 1'b1;
            c.alu_src_b   = ALU_B_RT;
            c.alu_control = d.alu_op;
            c.pc_src      = PC_SRC_ALU_OUT;
         end
         S_JUMP: begin
            c.pc_src      = PC_SRC_JUMP;
            c.pc_write    = 1'b1;
            c.reg_write   = d.link;
            c.write_to_ra = d.link;
            c.pc_to_reg   = d.link;
         end
         S_JUMP_REG: begin
            c.pc_src    = PC_SRC_RS;
            c.pc_write  = 1'b1;
            c.reg_write = d.link;
            c.reg_dst   = d.link;
            c.pc_to_reg = d.link;
         end
         S_TRAP: begin
            c.trap      = 1'b1;
            c.epc_write = 1'b1;
            c.pc_src    = PC_SRC_TRAP;
            c.pc_write  = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

   // A ready in the final allowed cycle still completes the access.
   assign timeout_hit  = TIMEOUT_ON && !mem.mem_ready && (wait_cnt == TIMEOUT_LAST);
   assign branch_taken = dec.branch_on_zero ? alu_zero : !alu_zero;

   // Next-state selection; memory states leave on ready or on timeout.
   always_comb begin
      next_state = state;
      case (state)
         S_RESET: next_state = S_FETCH;
         S_FETCH: begin
            if (mem.mem_ready)    next_state = S_DECODE;
            else if (timeout_hit) next_state = S_TRAP;
         end
         S_DECODE: begin
            case (dec.cls)
               CLS_LOAD, CLS_STORE: next_state = S_MEM_ADDR;
               CLS_R_ALU:           next_state = S_EXEC_R;
               CLS_I_ALU:           next_state = S_EXEC_I;
               CLS_BRANCH:          next_state = S_BRANCH;
               CLS_JUMP:            next_state = S_JUMP;
               CLS_JUMP_REG:        next_state = S_JUMP_REG;
               default: begin
                  if (TRAP_EN) next_state = S_TRAP;
                  else         next_state = S_FETCH;
               end
            endcase
         end
         S_MEM_ADDR: begin
            if (dec.cls == CLS_LOAD) next_state = S_MEM_READ;
            else                     next_state = S_MEM_WRITE;
         end
         S_MEM_READ: begin
            if (mem.mem_ready)    next_state = S_MEM_WB;
            else if (timeout_hit) next_state = S_TRAP;
         end
         S_MEM_WRITE: begin
            if (mem.mem_ready)    next_state = S_FETCH;
            else if (timeout_hit) next_state = S_TRAP;
         end
         S_EXEC_R, S_EXEC_I: next_state = S_ALU_WB;
         default:            next_state = S_FETCH;
      endcase
   end

   // FSM: state, registered Moore outputs, memory wait counter and trap cause.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_RESET;
         ctrl     <= '0;
         wait_cnt <= '0;
         cause_q  <= CAUSE_ILLEGAL;
      end else begin
         // NOTE: non-blocking so every register here samples the pre-edge state.
         state <= next_state;
         ctrl  <= moore_outputs(next_state, dec);
         if (is_req_state(next_state) && (next_state != state)) begin
            wait_cnt <= '0;
         end else if (TIMEOUT_ON && is_req_state(state) && !mem.mem_ready) begin
            wait_cnt <= wait_cnt + CW'(1);
         end
         if (next_state == S_TRAP) begin
            if (state == S_DECODE) cause_q <= CAUSE_ILLEGAL;
            else                   cause_q <= CAUSE_TIMEOUT;
         end
      end
   end

   // Mealy strobes: fetch completes on ready, branches write PC only when taken.
   assign ir_write = (state == S_FETCH) && mem.mem_ready;
   assign pc_write = ctrl.pc_write || ir_write || ((state == S_BRANCH) && branch_taken);

   assign mem.mem_req         = ctrl.mem_req;
   assign mem.iord            = ctrl.iord;
   assign mem.mem_write       = ctrl.mem_write;
   assign mem.mem_rw_size     = ctrl.mem_rw_size;
   assign mem.mem_read_signed = ctrl.mem_read_signed;

   assign pc_src          = ctrl.pc_src;
   assign reg_write       = ctrl.reg_write;
   assign reg_dst         = ctrl.reg_dst;
   assign mem_to_reg      = ctrl.mem_to_reg;
   assign pc_to_reg       = ctrl.pc_to_reg;
   assign write_to_ra     = ctrl.write_to_ra;
   assign alu_src_a       = ctrl.alu_src_a;
   assign alu_src_b       = ctrl.alu_src_b;
   assign alu_control     = ctrl.alu_control;
   assign use_shamt       = ctrl.use_shamt;
   assign imm_extend_mode = ctrl.imm_extend_mode;
   assign trap            = ctrl.trap;
   assign epc_write       = ctrl.epc_write;
   assign trap_cause      = cause_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit (MEM_TIMEOUT=4, TRAP_EN=1).
module tb_multicycle_control_unit;
   import multicycle_control_unit_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic [5:0] funct;
   logic       alu_zero;
   logic       ir_write, pc_write;
   logic [2:0] pc_src;
   logic       reg_write, reg_dst, mem_to_reg, pc_to_reg, write_to_ra, alu_src_a;
   logic [1:0] alu_src_b;
   logic [3:0] alu_control;
   logic       use_shamt, imm_extend_mode, trap, epc_write;
   logic [1:0] trap_cause;

   int n_checks = 0;
   int n_bad    = 0;

   multicycle_control_unit_if mem_if ();

   multicycle_control_unit #(
      .MEM_TIMEOUT (4),
      .TRAP_EN     (1'b1)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .op              (op),
      .funct           (funct),
      .alu_zero        (alu_zero),
      .mem             (mem_if),
      .ir_write        (ir_write),
      .pc_write        (pc_write),
      .pc_src          (pc_src),
      .reg_write       (reg_write),
      .reg_dst         (reg_dst),
      .mem_to_reg      (mem_to_reg),
      .pc_to_reg       (pc_to_reg),
      .write_to_ra     (write_to_ra),
      .alu_src_a       (alu_src_a),
      .alu_src_b       (alu_src_b),
      .alu_control     (alu_control),
      .use_shamt       (use_shamt),
      .imm_extend_mode (imm_extend_mode),
      .trap            (trap),
      .trap_cause      (trap_cause),
      .epc_write       (epc_write)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // FETCH with zero-wait memory, then step into DECODE.
   task automatic do_fetch(input logic [5:0] o, input logic [5:0] f, input string tag);
      op = o;
      funct = f;
      mem_if.mem_ready = 1'b1;
      #1;
      check({tag, ":fetch_state"}, dut.state, S_FETCH);
      check({tag, ":fetch_req"},   mem_if.mem_req, 1);
      check({tag, ":ir_write"},    ir_write, 1);
      check({tag, ":fetch_pcw"},   pc_write, 1);
      tick();
      mem_if.mem_ready = 1'b0;
      check({tag, ":decode_state"}, dut.state, S_DECODE);
      check({tag, ":decode_srcb"},  alu_src_b, 3);
   endtask

   initial begin
      rst_n = 1'b0;
      op = '0;
      funct = '0;
      alu_zero = 1'b0;
      mem_if.mem_ready = 1'b0;

      // Reset state, and ready is ignored outside a request state.
      #12;
      check("rst:state", dut.state, S_RESET);
      check("rst:req", mem_if.mem_req, 0);
      check("rst:cause", trap_cause, 0);
      mem_if.mem_ready = 1'b1;
      #1;
      check("rst:ir_write_ignored", ir_write, 0);
      check("rst:pc_write_ignored", pc_write, 0);
      mem_if.mem_ready = 1'b0;
      rst_n = 1'b1;
      tick();
      check("rst:to_fetch", dut.state, S_FETCH);
      check("fetch:wait_no_irw", ir_write, 0);
      check("fetch:srcb_four", alu_src_b, 1);
      check("fetch:alu_addu", alu_control, ALU_ADDU);

      // add $3,$1,$2
      do_fetch(OP_RTYPE, FN_ADD, "add");
      check("add:decode_ext", imm_extend_mode, 1);
      tick();
      check("add:exec_state", dut.state, S_EXEC_R);
      check("add:exec_srca", alu_src_a, 1);
      check("add:exec_srcb", alu_src_b, 0);
      check("add:exec_alu", alu_control, ALU_ADD);
      tick();
      check("add:wb_state", dut.state, S_ALU_WB);
      check("add:wb_regw", reg_write, 1);
      check("add:wb_dst", reg_dst, 1);
      check("add:wb_alu", alu_control, ALU_ADD);
      tick();
      check("add:done", dut.state, S_FETCH);

      // lh with three ready-less cycles; ready arrives on the last allowed cycle.
      do_fetch(OP_LH, 6'h00, "lh");
      tick();
      check("lh:addr_state", dut.state, S_MEM_ADDR);
      check("lh:addr_srcb", alu_src_b, 2);
      check("lh:addr_alu", alu_control, ALU_ADDU);
      tick();
      check("lh:rd_state", dut.state, S_MEM_READ);
      check("lh:rd_iord", mem_if.iord, 1);
      check("lh:rd_size", mem_if.mem_rw_size, 1);
      check("lh:rd_signed", mem_if.mem_read_signed, 1);
      tick();
      check("lh:wait2", dut.state, S_MEM_READ);
      tick();
      check("lh:wait3", dut.state, S_MEM_READ);
      tick();
      mem_if.mem_ready = 1'b1;
      #1;
      check("lh:ready_cycle", dut.state, S_MEM_READ);
      check("lh:ready_no_irw", ir_write, 0);
      tick();
      mem_if.mem_ready = 1'b0;
      check("lh:wb_state", dut.state, S_MEM_WB);
      check("lh:wb_regw", reg_write, 1);
      check("lh:wb_m2r", mem_to_reg, 1);
      check("lh:wb_dst", reg_dst, 0);
      check("lh:wb_size", mem_if.mem_rw_size, 1);
      check("lh:wb_signed", mem_if.mem_read_signed, 1);
      check("lh:wb_noreq", mem_if.mem_req, 0);
      tick();
      check("lh:done", dut.state, S_FETCH);

      // bgtz taken / not taken, beq taken
      alu_zero = 1'b0;
      do_fetch(OP_BGTZ, 6'h00, "bgtz_t");
      tick();
      check("bgtz_t:state", dut.state, S_BRANCH);
      check("bgtz_t:pcw", pc_write, 1);
      check("bgtz_t:pcsrc", pc_src, 1);
      check("bgtz_t:alu", alu_control, ALU_SGT);
      tick();
      check("bgtz_t:done", dut.state, S_FETCH);
      alu_zero = 1'b1;
      do_fetch(OP_BGTZ, 6'h00, "bgtz_n");
      tick();
      check("bgtz_n:pcw", pc_write, 0);
      check("bgtz_n:pcsrc", pc_src, 1);
      tick();
      check("bgtz_n:done", dut.state, S_FETCH);
      do_fetch(OP_BEQ, 6'h00, "beq_t");
      tick();
      check("beq_t:pcw", pc_write, 1);
      check("beq_t:alu", alu_control, ALU_SUBU);
      tick();
      alu_zero = 1'b0;

      // jal and jalr
      do_fetch(OP_JAL, 6'h00, "jal");
      tick();
      check("jal:pcsrc", pc_src, 2);
      check("jal:pcw", pc_write, 1);
      check("jal:regw", reg_write, 1);
      check("jal:ra", write_to_ra, 1);
      check("jal:p2r", pc_to_reg, 1);
      tick();
      do_fetch(OP_RTYPE, FN_JALR, "jalr");
      tick();
      check("jalr:pcsrc", pc_src, 3);
      check("jalr:dst", reg_dst, 1);
      check("jalr:p2r", pc_to_reg, 1);
      check("jalr:ra", write_to_ra, 0);
      tick();
      check("jalr:done", dut.state, S_FETCH);

      // addi (sign-extended) and ori (zero-extended)
      do_fetch(OP_ADDI, 6'h00, "addi");
      tick();
      check("addi:state", dut.state, S_EXEC_I);
      check("addi:alu", alu_control, ALU_ADD);
      check("addi:ext", imm_extend_mode, 1);
      check("addi:srcb", alu_src_b, 2);
      tick();
      check("addi:wb_dst", reg_dst, 0);
      check("addi:wb_regw", reg_write, 1);
      tick();
      do_fetch(OP_ORI, 6'h00, "ori");
      tick();
      check("ori:alu", alu_control, ALU_OR);
      check("ori:ext", imm_extend_mode, 0);
      tick();
      tick();

      // sw with memory never ready: trap after the fourth wait cycle
      do_fetch(OP_SW, 6'h00, "sw_to");
      tick();
      tick();
      check("sw_to:wr_state", dut.state, S_MEM_WRITE);
      check("sw_to:wr_strobe", mem_if.mem_write, 1);
      check("sw_to:wr_size", mem_if.mem_rw_size, 2);
      check("sw_to:wr_iord", mem_if.iord, 1);
      for (int i = 2; i <= 4; i++) begin
         tick();
         check($sformatf("sw_to:wait%0d", i), dut.state, S_MEM_WRITE);
      end
      tick();
      check("sw_to:trap_state", dut.state, S_TRAP);
      check("sw_to:trap", trap, 1);
      check("sw_to:cause", trap_cause, 1);
      check("sw_to:epc", epc_write, 1);
      check("sw_to:pcsrc", pc_src, 4);
      check("sw_to:no_wr", mem_if.mem_write, 0);
      tick();
      check("sw_to:back", dut.state, S_FETCH);
      check("sw_to:trap_pulse", trap, 0);
      check("sw_to:cause_hold", trap_cause, 1);

      // illegal opcode
      do_fetch(6'h3F, 6'h00, "ill");
      tick();
      check("ill:state", dut.state, S_TRAP);
      check("ill:trap", trap, 1);
      check("ill:epc", epc_write, 1);
      check("ill:pcsrc", pc_src, 4);
      check("ill:pcw", pc_write, 1);
      check("ill:cause", trap_cause, 0);
      tick();
      check("ill:back", dut.state, S_FETCH);

      // fetch timeout: no ir_write/pc_write on the final wait cycle
      tick();
      tick();
      tick();
      check("fto:last_state", dut.state, S_FETCH);
      check("fto:no_irw", ir_write, 0);
      check("fto:no_pcw", pc_write, 0);
      tick();
      check("fto:trap", trap, 1);
      check("fto:cause", trap_cause, 1);
      tick();

      // async reset in the middle of a store
      do_fetch(OP_SB, 6'h00, "rst_mid");
      tick();
      tick();
      check("rst_mid:wr", mem_if.mem_write, 1);
      check("rst_mid:size", mem_if.mem_rw_size, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid:req_drop", mem_if.mem_req, 0);
      check("rst_mid:wr_drop", mem_if.mem_write, 0);
      check("rst_mid:state", dut.state, S_RESET);
      check("rst_mid:cause", trap_cause, 0);
      tick();
      rst_n = 1'b1;
      #1;
      check("rst_mid:hold", dut.state, S_RESET);
      tick();
      check("rst_mid:fetch", dut.state, S_FETCH);
      check("rst_mid:fetch_req", mem_if.mem_req, 1);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
